bcd_display_scan: RTL and testbench
===================================

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, clock cycles per digit slot (legal range 2..65535).
REQ-002 SHALL have parameter DEAD, default 500, cycles at the start of each slot with all anodes off (legal range 0..PRESCALE-1).
REQ-003 SHALL have port clock, input, 1, single system clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port load, input, 1, one-cycle strobe capturing digits_in.
REQ-006 SHALL have port digits_in, input, 16, four BCD digits, [3:0] = digit 0 (least significant) ... [15:12] = digit 3.
REQ-007 SHALL have port blank_lz, input, 1, leading-zero blanking enable.
REQ-008 SHALL have port an, output, 4, one-hot active-low anode select, bit i = digit i.
REQ-009 SHALL have port seg, output, 7, active-low segments, seg[0]=a ... seg[6]=g.
REQ-010 SHALL have port frame_tick, output, 1, one-cycle pulse at each completed 4-digit scan frame.

Function
REQ-011 SHALL run a prescaler counting 0..PRESCALE-1 and wrapping to 0; slot_end is asserted when the count equals PRESCALE-1.
REQ-012 SHALL advance the digit index 0->1->2->3->0 on slot_end; the index is 2 bits and wraps with no other state.
REQ-013 SHALL pulse frame_tick for exactly one cycle, registered, in the cycle after the index wraps from 3 to 0.
REQ-014 On load, SHALL capture digits_in into a pending register and set pending_valid.
REQ-015 SHALL transfer pending into the display register only on a 3->0 wrap; it then clears pending_valid and sets disp_valid, so no frame mixes old and new digits.
REQ-016 When load coincides with a 3->0 wrap, SHALL transfer digits_in directly into the display register.
REQ-017 When a second load arrives before the wrap, SHALL overwrite pending; the last load wins.
REQ-018 While disp_valid=0, SHALL drive an=4'b1111 and seg=7'b1111111.
REQ-019 During prescaler counts 0..DEAD-1 of every slot, SHALL drive an=4'b1111; seg keeps the current digit pattern.
REQ-020 SHALL drive an and seg from registers, one clock after the prescaler/index state they reflect.
REQ-021 SHALL decode BCD 0-9 to standard seven-segment patterns and codes 10-15 to a dash (segment g only, seg=7'b0111111).
REQ-022 With blank_lz=1, SHALL blank digit i (1..3) when digit i and all higher digits are 0; digit 0 is never blanked.
REQ-023 A blanked digit SHALL drive seg=7'b1111111; its anode still follows REQ-019 timing.
REQ-024 blank_lz SHALL be sampled every cycle; it is not latched with load.

Reset
REQ-025 Asserting clear SHALL, independent of clock, zero the prescaler, index, pending, display register, pending_valid, disp_valid and frame_tick, and set an=4'b1111, seg=7'b1111111.
REQ-026 Deasserting clear SHALL start the prescaler at count 0 on the first following rising clock edge.
REQ-027 Asserting clear mid-slot or mid-frame SHALL discard any pending load.

Structure
REQ-028 A shared package SHALL hold: the digit count (4), the segment pattern constants for 0-9, the dash and blank patterns, and the anode-off constant.
REQ-029 The BCD-to-segment decode SHALL be a purely combinational sub-module bcd_to_seg7 (4-bit in, 7-bit active-low out), instantiated once on the muxed digit.
REQ-030 Prescaler width SHALL be the minimum needed to hold PRESCALE-1.

Verification (PRESCALE=4, DEAD=1)
REQ-031 Reset then load 16'h1234: an sequence 1110/1101/1011/0111 is seen, each for 3 cycles after 1 off cycle, with seg = 4/3/2/1 patterns respectively, starting only after the first frame wrap.
REQ-032 Load 16'h0007 with blank_lz=1: digits 3..1 show seg=7'b1111111 and digit 0 shows "7"; with blank_lz=0, the zeros are displayed.
REQ-033 Load 16'h00A5: digit 1 shows the dash 7'b0111111.
REQ-034 Load 16'h1111, then mid-frame load 16'h2222: the current frame finishes all "1"s and the next frame is all "2"s; load on the exact wrap cycle takes effect that frame.
REQ-035 Assert clear during slot 2: an=4'b1111 and seg=7'b1111111 immediately, without a clock edge; after release, the display stays dark until a new load and wrap.
REQ-036 frame_tick pulses once every 16 cycles and is never high on two consecutive cycles.

Source files
------------

// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the four-digit multiplexed seven-segment scanner.
// Segment patterns are active-low, bit 0 = a ... bit 6 = g.
package bcd_display_scan_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;
  typedef logic [NUM_DIGITS-1:0][3:0]    bcd_word_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

endpackage

// File: rtl/bcd_display_scan_seg7.sv
// BCD to active-low seven-segment decode; non-decimal codes show a dash.
// Latency: combinational.
// Backpressure: none.
module bcd_to_seg7
  import bcd_display_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed BCD display scanner with dead time and leading-zero blanking.
// Latency: an/seg are registered one clock after the scan state they show; loads appear at the next frame.
// Backpressure: none; load is a strobe and the last load before a frame wrap wins.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 500
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_tick
);

  localparam int            CW       = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);

  logic [CW-1:0] cnt;
  digit_idx_t    idx;
  logic          slot_end;
  logic          wrap;

  bcd_word_t     pend;
  bcd_word_t     disp;
  logic          pend_valid;
  logic          disp_valid;

  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;
  logic          blank_digit;
  logic          in_dead;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == digit_idx_t'(NUM_DIGITS - 1));
  assign in_dead  = (cnt < CNT_DEAD);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      frame_tick <= wrap;
      if (slot_end) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Display contents only change on a frame wrap so a frame never mixes old and new digits.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pend       <= '0;
      disp       <= '0;
      pend_valid <= 1'b0;
      disp_valid <= 1'b0;
    end else if (wrap && load) begin
      disp       <= digits_in;
      disp_valid <= 1'b1;
      pend_valid <= 1'b0;
    end else if (wrap && pend_valid) begin
      disp       <= pend;
      disp_valid <= 1'b1;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend       <= digits_in;
      pend_valid <= 1'b1;
    end
  end

  assign cur_digit = disp[idx];

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // A digit is a leading zero only if it and every more significant digit are zero.
  always_comb begin
    blank_digit = 1'b0;
    case (idx)
      2'd1:    blank_digit = (disp[3:1] == '0);
      2'd2:    blank_digit = (disp[3:2] == '0);
      2'd3:    blank_digit = (disp[3] == 4'd0);
      default: blank_digit = 1'b0;
    endcase
    blank_digit = blank_digit && blank_lz;
  end

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    if (disp_valid) begin
      if (!in_dead) begin
        an_nxt = ~(4'b0001 << idx);
      end
      if (!blank_digit) begin
        seg_nxt = dec_seg;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan at PRESCALE=4, DEAD=1: table of loaded words plus
// hand-written sequences for double loads, load-on-wrap and asynchronous clear.
module tb_bcd_display_scan;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct {
    logic [15:0]     dat;
    logic            blz;
    logic            ld;
    logic [3:0][6:0] exp;
  } vec_t;

  localparam int NV = 8;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs [NV];

  bcd_display_scan #(.PRESCALE(4), .DEAD(1)) dut (
    .clock      (clock),
    .clear      (clear),
    .load       (load),
    .digits_in  (digits_in),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Returns on the negedge of the cycle in which frame_tick is high.
  task automatic wait_tick(input logic want_dark);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clock);
      if (want_dark) begin
        chk("dark_an", {12'd0, an}, 16'h000F);
        chk("dark_seg", {9'd0, seg}, 16'h007F);
      end
      got = frame_tick;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_timeout: no frame_tick within 64 cycles at t=%0t", $time);
    end
  endtask

  // Checks the 16 cycles following a frame_tick; ends on the next frame_tick cycle.
  task automatic run_frame(input logic dark, input logic [3:0][6:0] exp,
                           input int l1_j, input logic [15:0] l1_d,
                           input int l2_j, input logic [15:0] l2_d,
                           input logic nblz);
    int s;
    int p;
    logic [3:0] ea;
    logic [6:0] es;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clock);
      s = (j - 1) / 4;
      p = (j - 1) % 4;
      case (s)
        0:       ea = 4'b1110;
        1:       ea = 4'b1101;
        2:       ea = 4'b1011;
        default: ea = 4'b0111;
      endcase
      if (dark || p == 0) ea = 4'b1111;
      es = dark ? SB : exp[s];
      chk("an", {12'd0, an}, {12'd0, ea});
      chk("seg", {9'd0, seg}, {9'd0, es});
      chk("frame_tick", {15'd0, frame_tick}, {15'd0, (j == 16)});
      load = 1'b0;
      if (j == l1_j) begin
        load = 1'b1;
        digits_in = l1_d;
      end
      if (j == l2_j) begin
        load = 1'b1;
        digits_in = l2_d;
      end
      if (j == 16) blank_lz = nblz;
    end
  endtask

  initial begin
    vecs[0] = '{dat: 16'h1234, blz: 1'b0, ld: 1'b1, exp: {S1, S2, S3, S4}};
    vecs[1] = '{dat: 16'h0007, blz: 1'b1, ld: 1'b1, exp: {SB, SB, SB, S7}};
    vecs[2] = '{dat: 16'h0007, blz: 1'b0, ld: 1'b0, exp: {S0, S0, S0, S7}};
    vecs[3] = '{dat: 16'h00A5, blz: 1'b0, ld: 1'b1, exp: {S0, S0, SD, S5}};
    vecs[4] = '{dat: 16'h0A05, blz: 1'b1, ld: 1'b1, exp: {SB, SD, S0, S5}};
    vecs[5] = '{dat: 16'h0000, blz: 1'b1, ld: 1'b1, exp: {SB, SB, SB, S0}};
    vecs[6] = '{dat: 16'h9860, blz: 1'b1, ld: 1'b1, exp: {S9, S8, S6, S0}};
    vecs[7] = '{dat: 16'hF0C3, blz: 1'b1, ld: 1'b1, exp: {SD, S0, SD, S3}};

    #1 clear = 1'b1;
    #11;
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_seg", {9'd0, seg}, 16'h007F);
    chk("rst_tick", {15'd0, frame_tick}, 16'h0000);

    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    load = 1'b1;
    digits_in = vecs[0].dat;
    blank_lz = vecs[0].blz;
    @(negedge clock);
    load = 1'b0;
    wait_tick(1'b1);

    for (int v = 0; v < NV; v++) begin
      if (v + 1 < NV)
        run_frame(1'b0, vecs[v].exp, vecs[v + 1].ld ? 6 : 0, vecs[v + 1].dat, 0, 16'h0,
                  vecs[v + 1].blz);
      else
        run_frame(1'b0, vecs[v].exp, 6, 16'h1111, 0, 16'h0, 1'b0);
    end

    // Two loads inside one frame: the later one wins, current frame is untouched.
    run_frame(1'b0, {S1, S1, S1, S1}, 5, 16'h3333, 10, 16'h4444, 1'b0);
    // Load on the wrap cycle itself lands in the very next frame.
    run_frame(1'b0, {S4, S4, S4, S4}, 15, 16'h5555, 0, 16'h0, 1'b0);

    // Pending load followed by clear during slot 2 must leave the display dark.
    for (int j = 1; j <= 11; j++) begin
      @(negedge clock);
      load = (j == 6);
      if (j == 6) digits_in = 16'h2222;
    end
    chk("slot2_an", {12'd0, an}, 16'h000B);
    chk("slot2_seg", {9'd0, seg}, {9'd0, S5});
    #2 clear = 1'b1;
    #1;
    chk("clr_an", {12'd0, an}, 16'h000F);
    chk("clr_seg", {9'd0, seg}, 16'h007F);
    chk("clr_tick", {15'd0, frame_tick}, 16'h0000);
    @(negedge clock);
    clear = 1'b0;
    wait_tick(1'b1);
    run_frame(1'b1, {SB, SB, SB, SB}, 6, 16'h6789, 0, 16'h0, 1'b0);
    run_frame(1'b0, {S6, S7, S8, S9}, 0, 16'h0, 0, 16'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
